// File: rtl/cpu_fpu_dispatch_pkg.sv
// Shared types and constants for the CPU-side FPU dispatcher.
// Covers the op encodings, the FSM states, the unit select and the canonical NaN.
package cpu_fpu_pkg;

   localparam logic [2:0]  FPU_OP_ADD = 3'd0;
   localparam logic [2:0]  FPU_OP_SUB = 3'd1;
   localparam logic [2:0]  FPU_OP_MUL = 3'd2;
   localparam logic [2:0]  FPU_OP_DIV = 3'd3;

   localparam logic [31:0] CANONICAL_NAN = 32'hFFC00000;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RELEASE,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      UNIT_ADD,
      UNIT_MUL,
      UNIT_DIV
   } unit_t;

   // ADD and SUB share the adder; SUB is realised by flipping the sign of op2.
   function automatic unit_t op_to_unit(input logic [2:0] op);
      unit_t u;
      case (op)
         FPU_OP_MUL: u = UNIT_MUL;
         FPU_OP_DIV: u = UNIT_DIV;
         default:    u = UNIT_ADD;
      endcase
      return u;
   endfunction

endpackage

// File: rtl/cpu_fpu_dispatch_timer.sv
// Saturating 16-bit ISSUE-phase cycle counter with an expiry flag.
// The expiry flag never asserts when TIMEOUT is zero.
module cpu_fpu_dispatch_timer
   import cpu_fpu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   // Limits beyond the counter range clamp to the saturation value.
   localparam logic [15:0] LIMIT =
      (TIMEOUT == 0)     ? 16'd0     :
      (TIMEOUT > 65536)  ? 16'hFFFF  :
                           16'(TIMEOUT - 1);

   logic [15:0] count;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + 16'd1;
      end
   end

   assign expire = (TIMEOUT != 0) && (count >= LIMIT);

endmodule

// File: rtl/cpu_fpu_dispatch.sv
// Dispatches one CPU floating-point request to the add, mul or div unit
// using level-held request/ready handshakes on both sides.
module cpu_fpu_dispatch
   import cpu_fpu_pkg::*;
#(
   parameter int unsigned TIMEOUT   = 64,
   parameter logic [31:0] NAN_VALUE = CANONICAL_NAN
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_request,
   input  logic [2:0]  i_op,
   input  logic [31:0] i_op1,
   input  logic [31:0] i_op2,
   output logic        o_ready,
   output logic [31:0] o_result,
   output logic        o_error,
   output logic        o_add_request,
   output logic [31:0] o_add_op1,
   output logic [31:0] o_add_op2,
   input  logic        i_add_ready,
   input  logic [31:0] i_add_result,
   output logic        o_mul_request,
   output logic [31:0] o_mul_op1,
   output logic [31:0] o_mul_op2,
   input  logic        i_mul_ready,
   input  logic [31:0] i_mul_result,
   output logic        o_div_request,
   output logic [31:0] o_div_op1,
   output logic [31:0] o_div_op2,
   input  logic        i_div_ready,
   input  logic [31:0] i_div_result
);

   state_t state_q, state_d;
   unit_t  sel_q;
   unit_t  new_unit;
   logic   legal_op;
   logic   sel_ready;
   logic [31:0] sel_result;
   logic   expire;

   logic accept, reject, unit_done, abort, release_done, retire;

   assign legal_op = ~i_op[2];
   assign new_unit = op_to_unit(i_op);

   always_comb begin
      sel_ready  = i_add_ready;
      sel_result = i_add_result;
      case (sel_q)
         UNIT_MUL: begin
            sel_ready  = i_mul_ready;
            sel_result = i_mul_result;
         end
         UNIT_DIV: begin
            sel_ready  = i_div_ready;
            sel_result = i_div_result;
         end
         default: ;
      endcase
   end

   cpu_fpu_dispatch_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .clear   (accept),
      .enable  (state_q == ISSUE),
      .expire  (expire)
   );

   always_comb begin
      state_d      = state_q;
      accept       = 1'b0;
      reject       = 1'b0;
      unit_done    = 1'b0;
      abort        = 1'b0;
      release_done = 1'b0;
      retire       = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_request) begin
               if (legal_op) begin
                  accept  = 1'b1;
                  state_d = ISSUE;
               end else begin
                  reject  = 1'b1;
                  state_d = DONE;
               end
            end
         end
         ISSUE: begin
            // A ready arriving on the expiry cycle still wins over the abort.
            if (sel_ready) begin
               unit_done = 1'b1;
               state_d   = RELEASE;
            end else if (expire) begin
               abort   = 1'b1;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            if (!sel_ready) begin
               release_done = 1'b1;
               state_d      = DONE;
            end
         end
         DONE: begin
            if (!i_request) begin
               retire  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q       <= IDLE;
         sel_q         <= UNIT_ADD;
         o_ready       <= 1'b0;
         o_result      <= '0;
         o_error       <= 1'b0;
         o_add_request <= 1'b0;
         o_add_op1     <= '0;
         o_add_op2     <= '0;
         o_mul_request <= 1'b0;
         o_mul_op1     <= '0;
         o_mul_op2     <= '0;
         o_div_request <= 1'b0;
         o_div_op1     <= '0;
         o_div_op2     <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            sel_q <= new_unit;
            case (new_unit)
               UNIT_MUL: begin
                  o_mul_op1     <= i_op1;
                  o_mul_op2     <= i_op2;
                  o_mul_request <= 1'b1;
               end
               UNIT_DIV: begin
                  o_div_op1     <= i_op1;
                  o_div_op2     <= i_op2;
                  o_div_request <= 1'b1;
               end
               default: begin
                  o_add_op1     <= i_op1;
                  o_add_op2     <= (i_op == FPU_OP_SUB) ? {~i_op2[31], i_op2[30:0]} : i_op2;
                  o_add_request <= 1'b1;
               end
            endcase
         end
         if (reject) begin
            o_result <= NAN_VALUE;
            o_error  <= 1'b1;
            o_ready  <= 1'b1;
         end
         if (unit_done || abort) begin
            o_add_request <= 1'b0;
            o_mul_request <= 1'b0;
            o_div_request <= 1'b0;
            o_result      <= unit_done ? sel_result : NAN_VALUE;
            o_error       <= abort;
         end
         if (release_done) begin
            o_ready <= 1'b1;
         end
         if (retire) begin
            o_ready <= 1'b0;
            o_error <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cpu_fpu_dispatch.sv
// Directed bench for cpu_fpu_dispatch with latency-programmable unit responders.
module tb_cpu_fpu_dispatch;

   logic        i_clock;
   logic        i_reset;
   logic        i_request;
   logic [2:0]  i_op;
   logic [31:0] i_op1, i_op2;
   logic        o_ready, o_error;
   logic [31:0] o_result;
   logic        o_add_request, o_mul_request, o_div_request;
   logic [31:0] o_add_op1, o_add_op2, o_mul_op1, o_mul_op2, o_div_op1, o_div_op2;
   logic        add_rdy, mul_rdy, div_rdy;
   logic        add_force;
   logic [31:0] add_res, mul_res, div_res;
   int          add_lat, mul_lat, div_lat;
   int          add_cnt, mul_cnt, div_cnt;
   int          multi_req;

   int checks   = 0;
   int failures = 0;

   cpu_fpu_dispatch #(
      .TIMEOUT   (16),
      .NAN_VALUE (32'hFFC00000)
   ) dut (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_request     (i_request),
      .i_op          (i_op),
      .i_op1         (i_op1),
      .i_op2         (i_op2),
      .o_ready       (o_ready),
      .o_result      (o_result),
      .o_error       (o_error),
      .o_add_request (o_add_request),
      .o_add_op1     (o_add_op1),
      .o_add_op2     (o_add_op2),
      .i_add_ready   (add_rdy | add_force),
      .i_add_result  (add_res),
      .o_mul_request (o_mul_request),
      .o_mul_op1     (o_mul_op1),
      .o_mul_op2     (o_mul_op2),
      .i_mul_ready   (mul_rdy),
      .i_mul_result  (mul_res),
      .o_div_request (o_div_request),
      .o_div_op1     (o_div_op1),
      .o_div_op2     (o_div_op2),
      .i_div_ready   (div_rdy),
      .i_div_result  (div_res)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   // Unit responders: ready rises LAT cycles after request is first seen (LAT=0: never).
   always @(posedge i_clock) begin
      if (!o_add_request) begin
         add_cnt <= 0; add_rdy <= 1'b0;
      end else if (add_lat != 0 && !add_rdy) begin
         if (add_cnt == add_lat - 1) add_rdy <= 1'b1;
         add_cnt <= add_cnt + 1;
      end
   end
   always @(posedge i_clock) begin
      if (!o_mul_request) begin
         mul_cnt <= 0; mul_rdy <= 1'b0;
      end else if (mul_lat != 0 && !mul_rdy) begin
         if (mul_cnt == mul_lat - 1) mul_rdy <= 1'b1;
         mul_cnt <= mul_cnt + 1;
      end
   end
   always @(posedge i_clock) begin
      if (!o_div_request) begin
         div_cnt <= 0; div_rdy <= 1'b0;
      end else if (div_lat != 0 && !div_rdy) begin
         if (div_cnt == div_lat - 1) div_rdy <= 1'b1;
         div_cnt <= div_cnt + 1;
      end
   end

   initial multi_req = 0;
   always @(negedge i_clock) begin
      if ({1'b0, o_add_request} + {1'b0, o_mul_request} + {1'b0, o_div_request} > 2'd1)
         multi_req <= multi_req + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Raises a request at a negedge and waits (bounded) for o_ready.
   task automatic run_txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic ok, output logic [2:0] req1,
                          output int req_cycles);
      i_op = op; i_op1 = a; i_op2 = b; i_request = 1'b1;
      lat = 0; ok = 1'b0; req1 = 3'b000; req_cycles = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge i_clock);
         lat = n + 1;
         if (n == 0) req1 = {o_add_request, o_mul_request, o_div_request};
         if (o_add_request || o_mul_request || o_div_request) req_cycles++;
         if (o_ready) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic drop_req(input string tag);
      logic cleared;
      cleared = 1'b0;
      i_request = 1'b0;
      for (int n = 0; n < 4; n++) begin
         @(negedge i_clock);
         if (!o_ready) begin
            cleared = 1'b1;
            break;
         end
      end
      chk({tag, "_ready_clear"}, {31'd0, cleared}, 32'd1);
      chk({tag, "_error_clear"}, {31'd0, o_error}, 32'd0);
   endtask

   int         lat, rc;
   logic       ok;
   logic [2:0] r1;

   initial begin
      i_reset = 1'b1; i_request = 1'b0; i_op = 3'd0; i_op1 = '0; i_op2 = '0;
      add_force = 1'b0;
      add_lat = 9; mul_lat = 5; div_lat = 3;
      add_res = 32'h40400000; mul_res = 32'h40C00000; div_res = 32'h40400000;
      repeat (2) @(negedge i_clock);
      chk("rst_ready",  {31'd0, o_ready}, 32'd0);
      chk("rst_result", o_result, 32'd0);
      chk("rst_error",  {31'd0, o_error}, 32'd0);
      chk("rst_reqs",   {29'd0, o_add_request, o_mul_request, o_div_request}, 32'd0);
      i_reset = 1'b0;
      @(negedge i_clock);
      chk("idle_ready", {31'd0, o_ready}, 32'd0);

      // ADD 1.0 + 2.0 through a 9-cycle adder: 9 + 4 cycles overhead
      run_txn(3'd0, 32'h3F800000, 32'h40000000, lat, ok, r1, rc);
      chk("add_ok",     {31'd0, ok}, 32'd1);
      chk("add_req1",   {29'd0, r1}, 32'b100);
      chk("add_lat",    lat, 13);
      chk("add_op1",    o_add_op1, 32'h3F800000);
      chk("add_op2",    o_add_op2, 32'h40000000);
      chk("add_result", o_result, 32'h40400000);
      chk("add_error",  {31'd0, o_error}, 32'd0);
      drop_req("add");

      // SUB 3.0 - 1.0: op2 sign flipped on the adder side
      add_res = 32'h40000000;
      run_txn(3'd1, 32'h40400000, 32'h3F800000, lat, ok, r1, rc);
      chk("sub_req1",   {29'd0, r1}, 32'b100);
      chk("sub_op1",    o_add_op1, 32'h40400000);
      chk("sub_op2",    o_add_op2, 32'hBF800000);
      chk("sub_result", o_result, 32'h40000000);
      drop_req("sub");

      // MUL 2.0 * 3.0 through a 5-cycle multiplier
      run_txn(3'd2, 32'h40000000, 32'h40400000, lat, ok, r1, rc);
      chk("mul_req1",   {29'd0, r1}, 32'b010);
      chk("mul_lat",    lat, 9);
      chk("mul_op1",    o_mul_op1, 32'h40000000);
      chk("mul_op2",    o_mul_op2, 32'h40400000);
      chk("mul_result", o_result, 32'h40C00000);
      chk("mul_add_op2_kept", o_add_op2, 32'hBF800000);
      drop_req("mul");

      // DIV 6.0 / 2.0 with a stray adder ready held high the whole time
      add_force = 1'b1;
      run_txn(3'd3, 32'h40C00000, 32'h40000000, lat, ok, r1, rc);
      chk("div_req1",   {29'd0, r1}, 32'b001);
      chk("div_lat",    lat, 7);
      chk("div_op1",    o_div_op1, 32'h40C00000);
      chk("div_op2",    o_div_op2, 32'h40000000);
      chk("div_result", o_result, 32'h40400000);
      chk("div_error",  {31'd0, o_error}, 32'd0);
      drop_req("div");
      add_force = 1'b0;

      // Illegal op 5: immediate NaN/error, no unit request
      run_txn(3'd5, 32'h12345678, 32'h9ABCDEF0, lat, ok, r1, rc);
      chk("ill_ok",     {31'd0, ok}, 32'd1);
      chk("ill_lat_le2", {31'd0, (lat <= 2)}, 32'd1);
      chk("ill_result", o_result, 32'hFFC00000);
      chk("ill_error",  {31'd0, o_error}, 32'd1);
      chk("ill_reqcyc", rc, 0);
      drop_req("ill");

      // Timeout: adder never ready, request held for exactly 16 ISSUE cycles
      add_lat = 0;
      run_txn(3'd0, 32'h3F800000, 32'h3F800000, lat, ok, r1, rc);
      chk("to_ok",      {31'd0, ok}, 32'd1);
      chk("to_reqcyc",  rc, 16);
      chk("to_lat",     lat, 18);
      chk("to_result",  o_result, 32'hFFC00000);
      chk("to_error",   {31'd0, o_error}, 32'd1);
      chk("to_add_req", {31'd0, o_add_request}, 32'd0);
      drop_req("to");

      // Asynchronous reset in the middle of ISSUE
      i_op = 3'd0; i_op1 = 32'h40A00000; i_op2 = 32'h40A00000; i_request = 1'b1;
      repeat (3) @(negedge i_clock);
      chk("mid_add_req_before", {31'd0, o_add_request}, 32'd1);
      #2 i_reset = 1'b1;
      #1;
      chk("mid_add_req", {31'd0, o_add_request}, 32'd0);
      chk("mid_ready",   {31'd0, o_ready}, 32'd0);
      chk("mid_add_op1", o_add_op1, 32'd0);
      @(negedge i_clock);
      i_reset = 1'b0; i_request = 1'b0;
      @(negedge i_clock);
      add_lat = 2; add_res = 32'h40000000;
      run_txn(3'd0, 32'h3F800000, 32'h3F800000, lat, ok, r1, rc);
      chk("post_ok",     {31'd0, ok}, 32'd1);
      chk("post_lat",    lat, 6);
      chk("post_op2",    o_add_op2, 32'h3F800000);
      chk("post_result", o_result, 32'h40000000);
      chk("post_error",  {31'd0, o_error}, 32'd0);
      drop_req("post");

      chk("one_hot_requests", multi_req, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
